// File: rtl/board_input_ports.sv
// rtl/board_input_ports.sv - debounced, parametrised input-port bank for the board switches
//
// Loads the synchronised switch bank into one of NUM_PORTS registers on each
// key press (optionally splitting the bank across two consecutive ports),
// tracks per-port valid/overrun status and offers a registered read port.
//
// Optional feature macro: BOARD_INPUT_PORTS_DEBOUNCE_EN
//   defined   - key passes through a DEB_CYCLES-stable debouncer
//   undefined - stable key level is the synchronised key (fast build)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   sw          raw switch bank (asynchronous)
//   key_load    raw load pushbutton, active-high (asynchronous)
//   sel         destination port of the next load
//   split       0: whole bank to sel; 1: upper half to sel, lower half to sel+1 (wrapping)
//   rd_en       read strobe
//   rd_addr     0..NUM_PORTS-1 reads a port, NUM_PORTS reads the valid vector
//   rd_data     registered read data
//   ports_flat  all port registers, port i at [i*DATA_W +: DATA_W]
//   valid       per port: loaded and not yet read
//   overrun     per port: reloaded while still valid

module board_input_ports #(
   parameter int DATA_W     = 8,
   parameter int NUM_PORTS  = 4,
   parameter int SW_W       = 10,
   parameter int DEB_CYCLES = 16,
   localparam int SEL_W     = $clog2(NUM_PORTS),
   localparam int ADDR_W    = $clog2(NUM_PORTS + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SW_W-1:0]               sw,
   input  logic                          key_load,
   input  logic [SEL_W-1:0]              sel,
   input  logic                          split,
   input  logic                          rd_en,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic [DATA_W-1:0]             rd_data,
   output logic [NUM_PORTS*DATA_W-1:0]   ports_flat,
   output logic [NUM_PORTS-1:0]          valid,
   output logic [NUM_PORTS-1:0]          overrun
);

   localparam int HALF = SW_W / 2;

   if (DEB_CYCLES < 2 || NUM_PORTS < 2 || NUM_PORTS > DATA_W || (SW_W % 2) != 0) begin : g_param_check
      $error("board_input_ports: illegal parameter combination");
   end

   // ---------------- input synchronisers ----------------
   logic [SW_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic            key_s1_q, key_s1_d, key_s2_q, key_s2_d;

   always_comb begin
      sw_s1_d  = sw;
      sw_s2_d  = sw_s1_q;
      key_s1_d = key_load;
      key_s2_d = key_s1_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         key_s1_q <= 1'b0;
         key_s2_q <= 1'b0;
      end else begin
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
         key_s1_q <= key_s1_d;
         key_s2_q <= key_s2_d;
      end
   end

   // ---------------- debouncer / stable key level ----------------
   logic stable_lvl;

`ifdef BOARD_INPUT_PORTS_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CYCLES);
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             stable_q, stable_d;

   // Counter only runs while the key disagrees with the stable level, so any
   // bounce back to the stable level restarts the qualification window.
   always_comb begin
      deb_cnt_d = '0;
      stable_d  = stable_q;
      if (key_s2_q != stable_q) begin
         if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            stable_d = ~stable_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         deb_cnt_q <= '0;
         stable_q  <= 1'b0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
         stable_q  <= stable_d;
      end
   end

   assign stable_lvl = stable_q;
`else
   assign stable_lvl = key_s2_q;
`endif

   // Rising edge of the stable level is the single-cycle load pulse.
   logic stable_prev_q, stable_prev_d;
   logic load;

   always_comb begin
      stable_prev_d = stable_lvl;
      load          = stable_lvl & ~stable_prev_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) stable_prev_q <= 1'b0;
      else        stable_prev_q <= stable_prev_d;
   end

   // ---------------- width adaptation of captured values ----------------
   logic [DATA_W-1:0] full_val, hi_val, lo_val, status_val;
   logic [NUM_PORTS-1:0] valid_q, valid_d, overrun_q, overrun_d;

   if (SW_W >= DATA_W) begin : g_full_trunc
      assign full_val = sw_s2_q[DATA_W-1:0];
   end else begin : g_full_ext
      assign full_val = {{(DATA_W - SW_W){1'b0}}, sw_s2_q};
   end

   if (HALF >= DATA_W) begin : g_half_trunc
      assign hi_val = sw_s2_q[HALF +: DATA_W];
      assign lo_val = sw_s2_q[DATA_W-1:0];
   end else begin : g_half_ext
      assign hi_val = {{(DATA_W - HALF){1'b0}}, sw_s2_q[SW_W-1:HALF]};
      assign lo_val = {{(DATA_W - HALF){1'b0}}, sw_s2_q[HALF-1:0]};
   end

   if (NUM_PORTS == DATA_W) begin : g_status_full
      assign status_val = valid_q;
   end else begin : g_status_ext
      assign status_val = {{(DATA_W - NUM_PORTS){1'b0}}, valid_q};
   end

   // ---------------- port registers, status, read path ----------------
   logic [DATA_W-1:0]    port_q [NUM_PORTS];
   logic [DATA_W-1:0]    port_d [NUM_PORTS];
   logic [DATA_W-1:0]    rd_data_q, rd_data_d;
   logic [NUM_PORTS-1:0] ld_hi_vec, ld_lo_vec, rd_hit_vec;
   int                   lo_idx;

   always_comb begin
      lo_idx     = (int'(sel) == NUM_PORTS - 1) ? 0 : int'(sel) + 1;
      ld_hi_vec  = '0;
      ld_lo_vec  = '0;
      rd_hit_vec = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         ld_hi_vec[i]  = load && (int'(sel) == i);
         ld_lo_vec[i]  = load && split && (lo_idx == i);
         rd_hit_vec[i] = rd_en && (int'(rd_addr) == i);
      end
   end

   always_comb begin
      port_d    = port_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      rd_data_d = rd_data_q;

      for (int i = 0; i < NUM_PORTS; i++) begin
         if (ld_hi_vec[i] || ld_lo_vec[i]) begin
            port_d[i]  = !split ? full_val : (ld_hi_vec[i] ? hi_val : lo_val);
            valid_d[i] = 1'b1;
            // A simultaneous read-clear consumes the previous data, so the
            // new load is not an overrun and any stale overrun is dropped.
            overrun_d[i] = rd_hit_vec[i] ? 1'b0 : (overrun_q[i] | valid_q[i]);
         end else if (rd_hit_vec[i]) begin
            valid_d[i]   = 1'b0;
            overrun_d[i] = 1'b0;
         end
      end

      if (rd_en) begin
         rd_data_d = '0;
         if (int'(rd_addr) == NUM_PORTS) begin
            rd_data_d = status_val;
         end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (rd_hit_vec[i]) rd_data_d = port_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= '0;
         valid_q   <= '0;
         overrun_q <= '0;
         rd_data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= port_d[i];
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         rd_data_q <= rd_data_d;
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_flat
      assign ports_flat[g*DATA_W +: DATA_W] = port_q[g];
   end

   assign rd_data = rd_data_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_board_input_ports.sv
// tb/tb_board_input_ports.sv - scoreboard bench for board_input_ports (default parameters)

module tb_board_input_ports;

   localparam int DEB = 16;
`ifdef BOARD_INPUT_PORTS_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  sw;
   logic        key_load;
   logic [1:0]  sel;
   logic        split;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [7:0]  rd_data;
   logic [31:0] ports_flat;
   logic [3:0]  valid;
   logic [3:0]  overrun;

   board_input_ports #(
      .DATA_W(8), .NUM_PORTS(4), .SW_W(10), .DEB_CYCLES(DEB)
   ) dut (
      .clk(clk), .reset(reset), .sw(sw), .key_load(key_load), .sel(sel),
      .split(split), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .ports_flat(ports_flat), .valid(valid), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_port [4];
   logic [3:0] exp_valid;
   logic [3:0] exp_overrun;
   logic [7:0] sb_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_flat"}, ports_flat,
            {exp_port[3], exp_port[2], exp_port[1], exp_port[0]});
      check({tag, "_valid"}, 32'(valid), 32'(exp_valid));
      check({tag, "_overrun"}, 32'(overrun), 32'(exp_overrun));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) exp_port[i] = 8'h00;
      exp_valid   = 4'b0000;
      exp_overrun = 4'b0000;
   endtask

   task automatic model_load(input int j, input logic [7:0] v);
      if (exp_valid[j]) exp_overrun[j] = 1'b1;
      exp_valid[j] = 1'b1;
      exp_port[j]  = v;
   endtask

   // Monitor: every read strobe accepted out of reset yields one rd_data word.
   logic       mon_fire;
   logic [7:0] mon_exp;
   always begin
      @(posedge clk);
      mon_fire = rd_en & reset;
      #1;
      if (mon_fire) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_data: got %0h with no expected entry queued", rd_data);
         end else begin
            mon_exp = sb_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(mon_exp));
         end
      end
   end

   task automatic do_read(input int a);
      rd_en   = 1'b1;
      rd_addr = a[2:0];
      if (a < 4) begin
         sb_q.push_back(exp_port[a]);
         exp_valid[a]   = 1'b0;
         exp_overrun[a] = 1'b0;
      end else if (a == 4) begin
         sb_q.push_back({4'b0000, exp_valid});
      end else begin
         sb_q.push_back(8'h00);
      end
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   // Press the key; the first edge after this call is edge 0 and the load
   // must land exactly at edge LAT.  Optionally read rd_a at the load edge.
   task automatic press(input logic [9:0] s, input int p, input logic sp,
                        input int hold_extra, input logic co_rd, input int rd_a);
      int lo;
      lo = (p == 3) ? 0 : p + 1;
      sw = s; sel = p[1:0]; split = sp; key_load = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      check("load_not_early", 32'(valid), 32'(exp_valid));
      if (co_rd) begin
         rd_en   = 1'b1;
         rd_addr = rd_a[2:0];
         sb_q.push_back(exp_port[rd_a]);
      end
      @(posedge clk); #1;
      rd_en = 1'b0;
      if (!sp) begin
         model_load(p, s[7:0]);
      end else begin
         model_load(p, {3'b000, s[9:5]});
         model_load(lo, {3'b000, s[4:0]});
      end
      if (co_rd) begin
         if (rd_a == p || (sp && rd_a == lo)) begin
            exp_overrun[rd_a] = 1'b0;
         end else begin
            exp_valid[rd_a]   = 1'b0;
            exp_overrun[rd_a] = 1'b0;
         end
      end
      check_state("load");
      repeat (hold_extra) @(posedge clk);
      #1;
      key_load = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; sw = '0; key_load = 1'b0; sel = '0; split = 1'b0;
      rd_en = 1'b0; rd_addr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_data", 32'(rd_data), 32'h0);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_overrun", 32'(overrun), 32'h0);
      check("reset_flat", ports_flat, 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Whole bank to port 1, truncated to 8 bits.
      press(10'h2A5, 1, 1'b0, 4, 1'b0, 0);
      check("port1_a5", 32'(ports_flat[15:8]), 32'h0A5);
      do_read(1);

      // Split with wrap from port 3 to port 0.
      press(10'b10110_01101, 3, 1'b1, 4, 1'b0, 0);
      check("split_port3", 32'(ports_flat[31:24]), 32'h16);
      check("split_port0", 32'(ports_flat[7:0]), 32'h0D);
      check("split_valid", 32'(valid), 32'b1001);
      do_read(4);

      // Two loads of port 2 without a read in between.
      press(10'h311, 2, 1'b0, 4, 1'b0, 0);
      press(10'h0C3, 2, 1'b0, 4, 1'b0, 0);
      check("ovr2_set", 32'(overrun[2]), 32'h1);
      do_read(5);
      do_read(2);
      check_state("after_rd2");
      repeat (3) @(posedge clk);
      #1;
      check("rd_hold", 32'(rd_data), 32'h0C3);

      // Short key glitch.
`ifdef BOARD_INPUT_PORTS_DEBOUNCE_EN
      sw = 10'h05A; sel = 2'd0; split = 1'b0; key_load = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      key_load = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      check_state("glitch");
`else
      press(10'h05A, 0, 1'b0, 7, 1'b0, 0);
`endif

      // Load of port 0 coinciding with a read of port 0 (port 0 is valid).
      press(10'h0E7, 0, 1'b0, 4, 1'b1, 0);
      check("co_valid0", 32'(valid[0]), 32'h1);
      check("co_overrun0", 32'(overrun[0]), 32'h0);

      // Reset in the middle of a press: no load may follow.
      sw = 10'h0FF; sel = 2'd1; split = 1'b0; key_load = 1'b1;
      repeat ((LAT > 2) ? LAT / 2 : 1) @(posedge clk);
      #1;
      reset = 1'b0; key_load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_state("reset_mid");
      check("reset_mid_rd", 32'(rd_data), 32'h0);
      reset = 1'b1;
      repeat (LAT + 4) @(posedge clk);
      #1;
      check_state("after_reset");

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
